// File: rtl/seven_segment_capture.sv
// seven_segment_capture: decodes a multiplexed seven-segment bus back into stability-filtered hex frames
module seven_segment_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   value_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic                  valid,
  output logic                  err_out
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [1:0] IDLE = 2'd0, COUNT = 2'd1, LOCKED = 2'd2;
  logic [DIGITS+7:0]   prev, smp;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [1:0]          state, state_nx;
  logic                acc, onehot, same, seg_bad, full;
  logic [3:0]          nib;
  logic [4*DIGITS-1:0] stage_val;
  logic [DIGITS-1:0]   stage_dp, stage_bad, mask;
  always_comb begin
    nib = 4'h0;
    seg_bad = 1'b0;
    case (seg_in[6:0])
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: seg_bad = 1'b1;
    endcase
  end
  // A changed one-hot sample restarts the count; a held sample in LOCKED never re-accepts
  always_comb begin
    smp = {an_in, seg_in};
    onehot = $onehot(an_in);
    same = smp == prev;
    state_nx = state;
    cnt_nx = cnt;
    acc = 1'b0;
    if (!onehot) begin
      state_nx = IDLE;
      cnt_nx = '0;
    end else if (state == IDLE || !same) begin
      cnt_nx = CW'(1);
      acc = STABLE_CYCLES == 1;
      state_nx = acc ? LOCKED : COUNT;
    end else if (state == COUNT) begin
      cnt_nx = cnt + CW'(1);
      acc = cnt_nx == CW'(STABLE_CYCLES);
      state_nx = acc ? LOCKED : COUNT;
    end
  end
  assign full = &mask;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= '0;
      cnt <= '0;
      state <= IDLE;
      stage_val <= '0;
      stage_dp <= '0;
      stage_bad <= '0;
      mask <= '0;
      value_out <= '0;
      dp_out <= '0;
      err_out <= 1'b0;
      valid <= 1'b0;
    end else begin
      prev <= smp;
      cnt <= cnt_nx;
      state <= state_nx;
      valid <= full;
      if (full) begin
        value_out <= stage_val;
        dp_out <= stage_dp;
        err_out <= |stage_bad;
      end
      // An accept on the frame edge seeds the next frame rather than being cleared
      for (int i = 0; i < DIGITS; i++) begin
        mask[i] <= (acc && an_in[i]) || (mask[i] && !full);
        stage_bad[i] <= (acc && an_in[i]) ? seg_bad : (stage_bad[i] && !full);
        if (acc && an_in[i]) begin
          stage_val[4*i +: 4] <= nib;
          stage_dp[i] <= seg_in[7];
        end
      end
    end
  end
endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture: scoreboard bench for the seven-segment capture block
module tb_seven_segment_capture;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] seg_in = '0, seg1 = '0;
  logic [3:0] an_in = '0;
  logic [1:0] an1 = '0;
  logic [15:0] value_out;
  logic [3:0] dp_out;
  logic valid, err_out;
  logic [7:0] value1;
  logic [1:0] dp1;
  logic valid1, err1;
  typedef struct packed {logic [15:0] v; logic [3:0] dp; logic err;} frame_t;
  frame_t exp_q[$];
  frame_t mon_e;
  int vectors = 0, errors = 0;

  seven_segment_capture #(.DIGITS(4), .STABLE_CYCLES(4)) u0 (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
    .value_out(value_out), .dp_out(dp_out), .valid(valid), .err_out(err_out));
  seven_segment_capture #(.DIGITS(2), .STABLE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .seg_in(seg1), .an_in(an1),
    .value_out(value1), .dp_out(dp1), .valid(valid1), .err_out(err1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_valid: got value %h expected no frame", value_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("frame_value", 32'(value_out), 32'(mon_e.v));
        chk("frame_dp", 32'(dp_out), 32'(mon_e.dp));
        chk("frame_err", 32'(err_out), 32'(mon_e.err));
      end
    end
  end

  task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
    an_in = a;
    seg_in = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame4(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3);
    drive(4'b0001, s0, 4);
    drive(4'b0010, s1, 4);
    drive(4'b0100, s2, 4);
    drive(4'b1000, s3, 4);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_value", 32'(value_out), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_err", 32'(err_out), 0);
    chk("reset_dp", 32'(dp_out), 0);
    rst = 1'b0;
    // basic frame, pulse exactly one cycle after the last accept
    exp_q.push_back('{16'h3210, 4'b0000, 1'b0});
    frame4(8'h3F, 8'h06, 8'h5B, 8'h4F);
    chk("pre_valid_t1", 32'(valid), 0);
    drive(4'b0000, 8'h00, 3);
    // too short: no accepts
    drive(4'b0001, 8'h3F, 3);
    drive(4'b0010, 8'h06, 3);
    drive(4'b0100, 8'h5B, 3);
    drive(4'b1000, 8'h4F, 3);
    drive(4'b0000, 8'h00, 4);
    // undecodable digit, then a clean frame
    exp_q.push_back('{16'h3010, 4'b0000, 1'b1});
    frame4(8'h3F, 8'h06, 8'h49, 8'h4F);
    drive(4'b0000, 8'h00, 2);
    exp_q.push_back('{16'h3210, 4'b0000, 1'b0});
    frame4(8'h3F, 8'h06, 8'h5B, 8'h4F);
    drive(4'b0000, 8'h00, 2);
    // letters and decimal point
    exp_q.push_back('{16'hFDBA, 4'b0010, 1'b0});
    frame4(8'h77, 8'hFC, 8'h5E, 8'h71);
    drive(4'b0000, 8'h00, 2);
    // long hold, then latest-wins re-accept
    exp_q.push_back('{16'h3210, 4'b0000, 1'b0});
    drive(4'b0001, 8'h3F, 20);
    drive(4'b0010, 8'h06, 4);
    drive(4'b0100, 8'h5B, 4);
    drive(4'b1000, 8'h4F, 4);
    drive(4'b0000, 8'h00, 2);
    exp_q.push_back('{16'h3218, 4'b0000, 1'b0});
    drive(4'b0001, 8'h3F, 4);
    drive(4'b0010, 8'h06, 4);
    drive(4'b0001, 8'h7F, 4);
    drive(4'b0100, 8'h5B, 4);
    drive(4'b1000, 8'h4F, 4);
    drive(4'b0000, 8'h00, 2);
    // non-one-hot anodes never accept; a glitch restarts the count
    drive(4'b0011, 8'h3F, 10);
    drive(4'b0000, 8'h3F, 10);
    drive(4'b0010, 8'h06, 4);
    drive(4'b0100, 8'h5B, 4);
    drive(4'b1000, 8'h4F, 4);
    drive(4'b0000, 8'h00, 3);
    drive(4'b0001, 8'h3F, 3);
    drive(4'b0001, 8'h3E, 1);
    drive(4'b0001, 8'h3F, 3);
    drive(4'b0000, 8'h00, 2);
    exp_q.push_back('{16'h3210, 4'b0000, 1'b0});
    drive(4'b0001, 8'h3F, 4);
    chk("pre_valid_t5", 32'(valid), 0);
    drive(4'b0000, 8'h00, 2);
    // reset mid-frame discards partial frame
    exp_q.push_back('{16'h3218, 4'b0000, 1'b0});
    frame4(8'h7F, 8'h06, 8'h5B, 8'h4F);
    drive(4'b0000, 8'h00, 2);
    drive(4'b0001, 8'h3F, 4);
    drive(4'b0010, 8'h06, 4);
    drive(4'b0100, 8'h5B, 4);
    an_in = '0;
    #1 rst = 1'b1;
    #2;
    chk("async_rst_value", 32'(value_out), 0);
    chk("async_rst_valid", 32'(valid), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0010, 8'h06, 4);
    drive(4'b0100, 8'h5B, 4);
    drive(4'b1000, 8'h4F, 4);
    drive(4'b0000, 8'h00, 4);
    exp_q.push_back('{16'h3210, 4'b0000, 1'b0});
    drive(4'b0001, 8'h3F, 4);
    drive(4'b0000, 8'h00, 3);
    // single-cycle acceptance variant
    an1 = 2'b01;
    seg1 = 8'h06;
    @(negedge clk);
    an1 = 2'b10;
    seg1 = 8'hBF;
    @(negedge clk);
    chk("s1_pre_valid", 32'(valid1), 0);
    an1 = 2'b00;
    @(negedge clk);
    chk("s1_valid", 32'(valid1), 1);
    chk("s1_value", 32'(value1), 32'h01);
    chk("s1_dp", 32'(dp1), 32'h2);
    chk("s1_err", 32'(err1), 0);
    @(negedge clk);
    chk("s1_single_pulse", 32'(valid1), 0);
    drive(4'b0000, 8'h00, 5);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
